// File: rtl/dmem_load_store_unit.sv
// rtl/dmem_load_store_unit.sv - word/byte load-store unit over a synchronous data memory
// Byte ops (LB/SB) are compiled in only when DMEM_BYTE_OPS_EN is defined.
module dmem_load_store_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        rsp_valid,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        busy
);

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
`ifdef DMEM_BYTE_OPS_EN
  localparam logic [5:0] OP_LB = 6'b100000;
  localparam logic [5:0] OP_SB = 6'b101000;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} state_t;

  state_t                state;
  logic [3:0]            count;
  logic                  is_store_q;
  logic                  is_byte_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           data_q;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic        op_ok, op_store, op_byte;
  logic        accept, word_misaligned, commit;
  logic [ADDR_WIDTH-1:0] index;
  logic [1:0]  lane;
  logic [31:0] mem_word, load_val, wdata;
  logic [7:0]  lane_byte;
  logic [3:0]  be;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^address[31:ADDR_WIDTH+2];

  always_comb begin
    op_ok    = 1'b0;
    op_store = 1'b0;
    op_byte  = 1'b0;
    case (opcode)
      OP_LW: op_ok = 1'b1;
      OP_SW: begin op_ok = 1'b1; op_store = 1'b1; end
`ifdef DMEM_BYTE_OPS_EN
      OP_LB: begin op_ok = 1'b1; op_byte = 1'b1; end
      OP_SB: begin op_ok = 1'b1; op_store = 1'b1; op_byte = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign accept          = req_valid & req_ready & op_ok;
  assign word_misaligned = !op_byte && (address[1:0] != 2'b00);

  assign index     = addr_q[ADDR_WIDTH+1:2];
  assign lane      = addr_q[1:0];
  assign mem_word  = mem[index];
  assign lane_byte = mem_word[{lane, 3'b000} +: 8];
  assign load_val  = is_byte_q ? {{24{lane_byte[7]}}, lane_byte} : mem_word;
  assign commit    = (state == S_ACCESS) && (count == 4'd0);

  // Byte stores replicate the low byte to every lane and enable only the addressed one.
  assign be    = is_byte_q ? (4'b0001 << lane) : 4'b1111;
  assign wdata = is_byte_q ? {4{data_q[7:0]}} : data_q;

  always_ff @(posedge clk) begin
    if (!rst && commit && is_store_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[index][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      read_data  <= 32'd0;
      misaligned <= 1'b0;
      busy       <= 1'b0;
      count      <= 4'd0;
      is_store_q <= 1'b0;
      is_byte_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            is_store_q <= op_store;
            is_byte_q  <= op_byte;
            addr_q     <= address[ADDR_WIDTH+1:0];
            data_q     <= store_data;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            if (word_misaligned) begin
              state      <= S_RESPOND;
              rsp_valid  <= 1'b1;
              misaligned <= 1'b1;
              read_data  <= 32'd0;
            end else begin
              state <= S_ACCESS;
              count <= 4'(LATENCY - 1);
            end
          end
        end
        S_ACCESS: begin
          if (count == 4'd0) begin
            read_data  <= is_store_q ? 32'd0 : load_val;
            misaligned <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= S_RESPOND;
          end else begin
            count <= count - 4'd1;
          end
        end
        S_RESPOND: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_load_store_unit.sv
// tb/tb_dmem_load_store_unit.sv - self-checking bench for dmem_load_store_unit
module tb_dmem_load_store_unit;

  localparam int LAT = 2;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_LB = 6'b100000;
  localparam logic [5:0] OP_SB = 6'b101000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  opcode;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        rsp_valid;
  logic [31:0] read_data;
  logic        misaligned;
  logic        busy;

  dmem_load_store_unit #(.ADDR_WIDTH(8), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .opcode     (opcode),
    .address    (address),
    .store_data (store_data),
    .rsp_valid  (rsp_valid),
    .read_data  (read_data),
    .misaligned (misaligned),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rd;
    logic        mis;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rd, input logic mis, input string tag);
    int   k;
    int   w;
    bit   seen;
    exp_t e;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, " ready_before"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    opcode     = op;
    address    = addr;
    store_data = data;
    sb.push_back('{rd: rd, mis: mis, lat: (mis ? 1 : LAT + 1)});
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    opcode     = 6'($urandom);
    address    = $urandom;
    store_data = $urandom;
    seen = 0;
    k = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check({tag, " ready_drop"}, {31'd0, req_ready}, 32'd0);
        check({tag, " busy"}, {31'd0, busy}, 32'd1);
      end
      if (rsp_valid) seen = 1;
    end
    e = sb.pop_front();
    if (!seen) begin
      check({tag, " rsp_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, " latency"}, 32'(k), 32'(e.lat));
      check({tag, " read_data"}, read_data, e.rd);
      check({tag, " misaligned"}, {31'd0, misaligned}, {31'd0, e.mis});
      @(negedge clk);
      check({tag, " rsp_one_cycle"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, " ready_after"}, {31'd0, req_ready}, 32'd1);
    end
  endtask

  task automatic ignored(input logic [5:0] op, input string tag);
    @(negedge clk);
    req_valid  = 1'b1;
    opcode     = op;
    address    = 32'd48;
    store_data = 32'h0BAD0BAD;
    repeat (3) begin
      @(negedge clk);
      check({tag, " ready_held"}, {31'd0, req_ready}, 32'd1);
      check({tag, " no_rsp"}, {31'd0, rsp_valid}, 32'd0);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{op: OP_SW, addr: 32'd36,          data: 32'hDEADBEEF, rd: 32'h0,        mis: 1'b0};
    vecs[1]  = '{op: OP_LW, addr: 32'd36,          data: 32'h0,        rd: 32'hDEADBEEF, mis: 1'b0};
    vecs[2]  = '{op: OP_LW, addr: 32'd36 + 32'd1024, data: 32'h0,      rd: 32'hDEADBEEF, mis: 1'b0};
    vecs[3]  = '{op: OP_SW, addr: 32'd32,          data: 32'h12345678, rd: 32'h0,        mis: 1'b0};
    vecs[4]  = '{op: OP_LW, addr: 32'd34,          data: 32'h0,        rd: 32'h0,        mis: 1'b1};
    vecs[5]  = '{op: OP_LW, addr: 32'd32,          data: 32'h0,        rd: 32'h12345678, mis: 1'b0};
    vecs[6]  = '{op: OP_SW, addr: 32'd35,          data: 32'hFFFFFFFF, rd: 32'h0,        mis: 1'b1};
    vecs[7]  = '{op: OP_LW, addr: 32'd32,          data: 32'h0,        rd: 32'h12345678, mis: 1'b0};
    vecs[8]  = '{op: OP_SW, addr: 32'd40,          data: 32'hCAFEF00D, rd: 32'h0,        mis: 1'b0};
    vecs[9]  = '{op: OP_LW, addr: 32'd40,          data: 32'h0,        rd: 32'hCAFEF00D, mis: 1'b0};
    vecs[10] = '{op: OP_SW, addr: 32'h000003FC,    data: 32'hA5A5A5A5, rd: 32'h0,        mis: 1'b0};
    vecs[11] = '{op: OP_LW, addr: 32'hFFFFFFFC,    data: 32'h0,        rd: 32'hA5A5A5A5, mis: 1'b0};

    rst        = 1'b1;
    req_valid  = 1'b0;
    opcode     = 6'd0;
    address    = 32'd0;
    store_data = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset read_data", read_data, 32'd0);
    check("reset misaligned", {31'd0, misaligned}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_req(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].rd, vecs[i].mis,
              $sformatf("vec%0d", i));
    end

    begin : reset_at_commit
      bit stray;
      @(negedge clk);
      req_valid  = 1'b1;
      opcode     = OP_SW;
      address    = 32'd40;
      store_data = 32'd5;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (LAT) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("abort req_ready", {31'd0, req_ready}, 32'd1);
      check("abort busy", {31'd0, busy}, 32'd0);
      stray = 0;
      repeat (4) begin
        @(negedge clk);
        if (rsp_valid) stray = 1;
      end
      check("abort no_late_rsp", {31'd0, stray}, 32'd0);
    end
    run_req(OP_LW, 32'd40, 32'd0, 32'hCAFEF00D, 1'b0, "abort_reload");

    ignored(6'b000000, "unsupported_op");

`ifdef DMEM_BYTE_OPS_EN
    run_req(OP_SW, 32'd44, 32'h11223344, 32'h0,        1'b0, "byte_sw");
    run_req(OP_SB, 32'd45, 32'h000000F0, 32'h0,        1'b0, "byte_sb");
    run_req(OP_LB, 32'd45, 32'h0,        32'hFFFFFFF0, 1'b0, "byte_lb_neg");
    run_req(OP_LW, 32'd44, 32'h0,        32'h1122F044, 1'b0, "byte_lw");
    run_req(OP_LB, 32'd44, 32'h0,        32'h00000044, 1'b0, "byte_lb_pos");
`else
    ignored(OP_LB, "lb_disabled");
    ignored(OP_SB, "sb_disabled");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_load_store_unit.md
Name: dmem_load_store_unit

Overview:
- Responder side of the ALU's load/store address path: accepts the effective address (rs_content + sign-extended immediate) that the ALU produces for LW/SW.
- Performs the word access against an internal synchronous data memory and returns load data, or commits store data.
- Multi-cycle with a valid/ready request handshake and a one-cycle response strobe; the pipeline stalls on busy.

Parameters:
- ADDR_WIDTH, 8: word-address bits; memory holds 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2: cycles spent in ACCESS per aligned request; legal range 1..15.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept; high only in IDLE.
- opcode  input  6  6'b100011 LW, 6'b101011 SW (plus byte ops under option).
- address  input  32  effective byte address from ALU_result.
- store_data  input  32  rt_content for SW.
- rsp_valid  output  1  one-cycle response strobe.
- read_data  output  32  load result; valid while rsp_valid=1.
- misaligned  output  1  error flag; valid while rsp_valid=1.
- busy  output  1  high in ACCESS and RESPOND.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, req_ready=1, rsp_valid=0, read_data=0, misaligned=0, busy=0, counter=0. Memory contents are not cleared.
- Accept: req_valid & req_ready sampled high at edge E0. The unit latches opcode, address and store_data; inputs may change afterwards.
- Unsupported opcode with req_valid=1: not accepted, state stays IDLE, no response, no memory change.
- Word index = address[ADDR_WIDTH+1:2]. Address bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo 4*2**ADDR_WIDTH.
- States:
  - IDLE: on accept, if address[1:0]!=0 go to RESPOND with misaligned=1, read_data=0 and no write. Otherwise go to ACCESS with counter=LATENCY-1.
  - ACCESS: each edge decrements counter. At the edge where counter==0:
    - LW: read_data <= mem[index].
    - SW: mem[index] <= store_data and read_data <= 0.
    - Then go to RESPOND.
  - RESPOND: rsp_valid=1 for exactly one cycle, then IDLE with rsp_valid=0.
- Timing: aligned response is sampled at edge E0+LATENCY+1; misaligned response at E0+1. req_ready returns high the cycle after rsp_valid.
- Back-to-back: a new request is accepted no earlier than the edge at which RESPOND exits. No overlap, no pipelining.
- SW then LW to the same address returns the stored value (the write commits before the response).
- Reset mid-operation: aborts immediately. Reset in ACCESS, including the commit edge, suppresses the write because reset has priority. No rsp_valid is emitted for the aborted request.
- read_data and misaligned hold their values after RESPOND until the next response. They are meaningful only when rsp_valid=1.

Optional Feature:
- Macro DMEM_BYTE_OPS_EN.
- Defined: also accepts LB 6'b100000 and SB 6'b101000.
  - Byte lane = address[1:0] (little-endian); these ops are never misaligned.
  - LB returns the sign-extended byte.
  - SB writes only the selected byte of mem[index].
  - Both use the same LATENCY and FSM.
- Undefined: LB/SB are unsupported opcodes (ignored as above); only word ops exist.

Test Plan:
- Reset then SW address=36, store_data=32'hDEADBEEF, LATENCY=2 -> req_ready drops after E0; rsp_valid sampled only at E0+3; misaligned=0; read_data=0.
- LW address=36 after the previous step -> rsp_valid at E0+3 with read_data=32'hDEADBEEF; LW address=36+4*256 (wrap) returns the same value.
- LW address=34 (rs 15 + imm 19) -> rsp_valid at E0+1, misaligned=1, read_data=0; a following LW address=32 shows that word unchanged.
- SW address=40, data=5, with rst pulsed at the commit edge -> no rsp_valid, req_ready=1 next cycle; a subsequent LW address=40 returns the prior content (not 5).
- opcode=6'b000000 with req_valid=1 for 3 cycles -> req_ready stays 1, rsp_valid never asserts.
- DMEM_BYTE_OPS_EN defined: SW 44 = 32'h11223344, then SB 45 with data 8'hF0, then LB 45 -> read_data=32'hFFFFFFF0; LW 44 -> 32'h1122F044.
